// File: rtl/cpu_run_pkg.sv
// Shared definitions for the MIPS run controller.
//   run_state_e   : HOLD (core held in reset), RUN (core executing),
//                   DONE (run finished, core parked)
//   DEF_PASS_CODE : default test_out value that ends a run as passed
//   DEF_FAIL_CODE : default test_out value that ends a run as failed
//   sigStep       : one signature step, rotl1(sig) ^ val, confined to a
//                   width of w bits (w <= 64); the RTL and the bench
//                   reference model both use it
package cpu_run_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_e;

  localparam logic [31:0] DEF_PASS_CODE = 32'h600D_600D;
  localparam logic [31:0] DEF_FAIL_CODE = 32'hBAD0_BAD0;

  // The signature is carried in a 64-bit container so one function serves
  // every DATA_W up to 64; bits above w are masked off on the way out.
  function automatic logic [63:0] sigStep(input logic [63:0] sig,
                                          input logic [63:0] val,
                                          input int unsigned w);
    logic [63:0] mask;
    logic [63:0] rot;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    rot  = ((sig << 1) | ((sig & mask) >> (w - 1))) & mask;
    return (rot ^ val) & mask;
  endfunction

endpackage

// File: rtl/run_sig_acc.sv
// Signature accumulator for the run controller.
// Keeps the previous test_out sample, flags when test_out changes, and
// folds each changed value into a rotate-XOR signature.
// Ports:
//   clk_i       : clock, rising edge
//   rest_i      : synchronous active-low reset
//   clear_i     : clear prev and signature (start of a run); wins over en_i
//   en_i        : sample test_out and update the signature this cycle
//   test_out_i  : core observation word
//   changed_o   : test_out_i differs from the stored previous sample
//   signature_o : accumulated signature
module run_sig_acc
  import cpu_run_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rest_i,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] test_out_i,
  output logic              changed_o,
  output logic [DATA_W-1:0] signature_o
);

  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] sig_q, sig_d;

  assign changed_o   = (test_out_i != prev_q);
  assign signature_o = sig_q;

  // Next prev/signature: clear at run start, otherwise only move while enabled.
  always_comb begin
    prev_d = prev_q;
    sig_d  = sig_q;
    if (clear_i) begin
      prev_d = '0;
      sig_d  = '0;
    end else if (en_i) begin
      prev_d = test_out_i;
      if (changed_o) begin
        sig_d = DATA_W'(sigStep(64'(sig_q), 64'(test_out_i), DATA_W));
      end
    end
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rest_i) begin
      prev_q <= '0;
      sig_q  <= '0;
    end else begin
      prev_q <= prev_d;
      sig_q  <= sig_d;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the MIPS core: holds the core in reset for RST_CYCLES
// cycles, lets it run while watching test_out, and stops on the pass code,
// the fail code or after MAX_CYCLES run cycles. The result, the number of
// run cycles and a signature of test_out changes stay visible in DONE
// until start launches a new run.
// Optional feature macro: CPU_RUN_HANG_DETECT_EN adds a stall counter that
// ends the run as a failure (with hang=1) once test_out has stayed unchanged
// long enough; HANG_CYCLES must then be >= 2.
// Ports:
//   clk         : clock, rising edge
//   rest        : synchronous active-low reset, overrides everything
//   start       : begin a new run (only acted on in DONE)
//   test_out    : core observation word
//   cpu_rest    : active-high reset to the core
//   running     : high in RUN
//   done        : high in DONE
//   pass        : run ended on PASS_CODE
//   fail        : run ended on FAIL_CODE (or hang)
//   timeout     : run ended after MAX_CYCLES cycles
//   cycle_count : RUN cycles elapsed
//   signature   : rotate-XOR signature of test_out changes
//   hang        : run ended on a stall (only with CPU_RUN_HANG_DETECT_EN)
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                CNT_W       = 32,
  parameter int                RST_CYCLES  = 4,
  parameter int                MAX_CYCLES  = 10000,
  parameter logic [DATA_W-1:0] PASS_CODE   = DATA_W'(DEF_PASS_CODE),
  parameter logic [DATA_W-1:0] FAIL_CODE   = DATA_W'(DEF_FAIL_CODE),
  parameter int                HANG_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              start,
  input  logic [DATA_W-1:0] test_out,
  output logic              cpu_rest,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [DATA_W-1:0] signature
`ifdef CPU_RUN_HANG_DETECT_EN
  ,
  output logic              hang
`endif
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  run_state_e        state_q, state_d;
  logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
  logic [CNT_W-1:0]  cycleCnt_q, cycleCnt_d;
  logic              cpuRest_q, cpuRest_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              timeout_q, timeout_d;
  logic              sigClear, sigEn, changed;

`ifdef CPU_RUN_HANG_DETECT_EN
  localparam int STALL_W = (HANG_CYCLES > 2) ? $clog2(HANG_CYCLES) : 1;

  logic [STALL_W-1:0] stallCnt_q, stallCnt_d;
  logic               hang_q, hang_d;
  logic               hangHit;

  // Stall counter: restarts on every test_out change, counts unchanged RUN
  // cycles otherwise. The hang fires on the edge where it reaches its limit.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (sigClear) begin
      stallCnt_d = '0;
    end else if (state_q == RUN) begin
      stallCnt_d = changed ? '0 : stallCnt_q + STALL_W'(1);
    end
  end

  assign hangHit = (state_q == RUN) && (stallCnt_d == STALL_W'(HANG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rest) begin
      stallCnt_q <= '0;
      hang_q     <= 1'b0;
    end else begin
      stallCnt_q <= stallCnt_d;
      hang_q     <= hang_d;
    end
  end

  assign hang = hang_q;
`endif

  run_sig_acc #(
    .DATA_W (DATA_W)
  ) u_sig_acc (
    .clk_i       (clk),
    .rest_i      (rest),
    .clear_i     (sigClear),
    .en_i        (sigEn),
    .test_out_i  (test_out),
    .changed_o   (changed),
    .signature_o (signature)
  );

  // Next state and registered outputs. Termination priority in RUN is
  // pass, fail, (hang), timeout; the terminating edge still counts a cycle
  // and still updates the signature.
  always_comb begin
    state_d    = state_q;
    holdCnt_d  = holdCnt_q;
    cycleCnt_d = cycleCnt_q;
    cpuRest_d  = cpuRest_q;
    running_d  = running_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    timeout_d  = timeout_q;
    sigClear   = 1'b0;
    sigEn      = 1'b0;
`ifdef CPU_RUN_HANG_DETECT_EN
    hang_d     = hang_q;
`endif
    case (state_q)
      HOLD: begin
        cpuRest_d = 1'b1;
        running_d = 1'b0;
        if (holdCnt_q == HOLD_W'(RST_CYCLES - 1)) begin
          state_d    = RUN;
          holdCnt_d  = '0;
          cpuRest_d  = 1'b0;
          running_d  = 1'b1;
          cycleCnt_d = '0;
          sigClear   = 1'b1;
        end else begin
          holdCnt_d = holdCnt_q + HOLD_W'(1);
        end
      end
      RUN: begin
        sigEn      = 1'b1;
        cycleCnt_d = cycleCnt_q + CNT_W'(1);
        if (test_out == PASS_CODE) begin
          pass_d  = 1'b1;
          state_d = DONE;
        end else if (test_out == FAIL_CODE) begin
          fail_d  = 1'b1;
          state_d = DONE;
`ifdef CPU_RUN_HANG_DETECT_EN
        end else if (hangHit) begin
          fail_d  = 1'b1;
          hang_d  = 1'b1;
          state_d = DONE;
`endif
        end else if (cycleCnt_q == CNT_W'(MAX_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
        if (state_d == DONE) begin
          done_d    = 1'b1;
          running_d = 1'b0;
          cpuRest_d = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_d   = HOLD;
          holdCnt_d = '0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          timeout_d = 1'b0;
`ifdef CPU_RUN_HANG_DETECT_EN
          hang_d    = 1'b0;
`endif
        end
      end
      default: begin
        state_d   = HOLD;
        holdCnt_d = '0;
        cpuRest_d = 1'b1;
        running_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rest) begin
      state_q    <= HOLD;
      holdCnt_q  <= '0;
      cycleCnt_q <= '0;
      cpuRest_q  <= 1'b1;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      holdCnt_q  <= holdCnt_d;
      cycleCnt_q <= cycleCnt_d;
      cpuRest_q  <= cpuRest_d;
      running_q  <= running_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
    end
  end

  assign cpu_rest    = cpuRest_q;
  assign running     = running_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycleCnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl (RST_CYCLES=4, MAX_CYCLES=20,
// HANG_CYCLES=8). Expected run results go into a scoreboard queue when a
// run's stimulus is set up and are popped when the DUT reports done.
module tb_cpu_run_ctrl;
  import cpu_run_pkg::*;

  localparam int          RST_CYC  = 4;
  localparam int          MAX_CYC  = 20;
  localparam int          HANG_CYC = 8;
  localparam logic [31:0] PASSC    = 32'h600D_600D;
  localparam logic [31:0] FAILC    = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rest;
  logic        start;
  logic [31:0] testOut;
  logic        cpuRest, running, done, pass, fail, timeout;
  logic [31:0] cycleCount, signature;
`ifdef CPU_RUN_HANG_DETECT_EN
  logic        hang;
`endif

  typedef struct {
    logic        p;
    logic        f;
    logic        t;
    logic        h;
    logic [31:0] cnt;
    logic [31:0] sig;
  } exp_t;

  exp_t        sbQ[$];
  exp_t        lastExp;
  logic [31:0] curSeq[$];
  int          checks = 0;
  int          errors = 0;

  cpu_run_ctrl #(
    .DATA_W      (32),
    .CNT_W       (32),
    .RST_CYCLES  (RST_CYC),
    .MAX_CYCLES  (MAX_CYC),
    .PASS_CODE   (PASSC),
    .FAIL_CODE   (FAILC),
    .HANG_CYCLES (HANG_CYC)
  ) dut (
    .clk         (clk),
    .rest        (rest),
    .start       (start),
    .test_out    (testOut),
    .cpu_rest    (cpuRest),
    .running     (running),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .cycle_count (cycleCount),
    .signature   (signature)
`ifdef CPU_RUN_HANG_DETECT_EN
    ,
    .hang        (hang)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input logic p, input logic f, input logic t, input logic h,
                         input logic [31:0] cnt, input logic [31:0] sig);
    exp_t e;
    e.p = p; e.f = f; e.t = t; e.h = h; e.cnt = cnt; e.sig = sig;
    sbQ.push_back(e);
  endtask

  // Reference model of one run over curSeq (last value repeats).
  task automatic modelRun();
    logic [31:0] prev, sig, v;
    int          cnt, stall, idx;
    exp_t        e;
    prev = '0; sig = '0; cnt = 0; stall = 0;
    e.p = 1'b0; e.f = 1'b0; e.t = 1'b0; e.h = 1'b0;
    for (int k = 0; k < MAX_CYC; k++) begin
      idx = (k < curSeq.size()) ? k : curSeq.size() - 1;
      v = curSeq[idx];
      cnt++;
      if (v != prev) begin
        sig   = 32'(sigStep(64'(sig), 64'(v), 32));
        stall = 0;
      end else begin
        stall++;
      end
      prev = v;
      if (v == PASSC) begin
        e.p = 1'b1; break;
      end else if (v == FAILC) begin
        e.f = 1'b1; break;
`ifdef CPU_RUN_HANG_DETECT_EN
      end else if (stall == HANG_CYC - 1) begin
        e.f = 1'b1; e.h = 1'b1; break;
`endif
      end else if (cnt == MAX_CYC) begin
        e.t = 1'b1; break;
      end
    end
    e.cnt = 32'(cnt);
    e.sig = sig;
    sbQ.push_back(e);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_cpu_rest"}, cpuRest, 1);
    checkOutput({tag, "_running"}, running, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_pass"}, pass, 0);
    checkOutput({tag, "_fail"}, fail, 0);
    checkOutput({tag, "_timeout"}, timeout, 0);
    checkOutput({tag, "_count"}, cycleCount, 0);
    checkOutput({tag, "_sig"}, signature, 0);
  endtask

  // Called just after the edge that left the DUT in HOLD with a fresh hold
  // count; cpu_rest must stay high for exactly RST_CYC cycles.
  task automatic checkHold(input int startAt);
    for (int i = 0; i < RST_CYC; i++) begin
      checkOutput("hold_cpu_rest", cpuRest, 1);
      checkOutput("hold_running", running, 0);
      start = (i == startAt);
      tick();
      start = 1'b0;
    end
    checkOutput("run_cpu_rest", cpuRest, 0);
    checkOutput("run_running", running, 1);
    checkOutput("run_count0", cycleCount, 0);
    checkOutput("run_sig0", signature, 0);
  endtask

  // Drive curSeq into a running DUT until done (bounded), then score it.
  task automatic applyStimulus(input string tag);
    int   k, idx;
    exp_t e;
    k = 0;
    while (!done && k < 100) begin
      idx = (k < curSeq.size()) ? k : curSeq.size() - 1;
      testOut = curSeq[idx];
      tick();
      k++;
    end
    checkOutput({tag, "_done"}, done, 1);
    e = sbQ.pop_front();
    lastExp = e;
    checkOutput({tag, "_pass"}, pass, e.p);
    checkOutput({tag, "_fail"}, fail, e.f);
    checkOutput({tag, "_timeout"}, timeout, e.t);
`ifdef CPU_RUN_HANG_DETECT_EN
    checkOutput({tag, "_hang"}, hang, e.h);
`endif
    checkOutput({tag, "_count"}, cycleCount, e.cnt);
    checkOutput({tag, "_sig"}, signature, e.sig);
    checkOutput({tag, "_running"}, running, 0);
    checkOutput({tag, "_cpu_rest"}, cpuRest, 1);
  endtask

  task automatic startRun(input int startAt);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("restart_done", done, 0);
    checkOutput("restart_flags", {pass, fail, timeout}, 3'b000);
    checkHold(startAt);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rest = 1'b0; start = 1'b0; testOut = 32'h1234;
    tick();
    tick();
    checkReset("reset");
    rest = 1'b1;
    testOut = '0;
    checkHold(-1);

    // Zeros then the pass code on the tenth run cycle.
    curSeq = {};
    repeat (9) curSeq.push_back(32'h0);
    curSeq.push_back(PASSC);
`ifdef CPU_RUN_HANG_DETECT_EN
    pushExp(1'b0, 1'b1, 1'b0, 1'b1, 32'd7, 32'h0);
`else
    pushExp(1'b1, 1'b0, 1'b0, 1'b0, 32'd10, PASSC);
`endif
    applyStimulus("pass10");

    // DONE holds its results while test_out keeps moving.
    testOut = 32'h55;
    tick();
    testOut = 32'hAA;
    tick();
    checkOutput("hold_done", done, 1);
    checkOutput("hold_count", cycleCount, lastExp.cnt);
    checkOutput("hold_sig", signature, lastExp.sig);
    startRun(-1);

    // 1,2,2,3,FAIL: sig 1 -> 0 -> (no change) -> 3 -> rotl(3)^FAIL.
    curSeq = {32'd1, 32'd2, 32'd2, 32'd3, FAILC};
    pushExp(1'b0, 1'b1, 1'b0, 1'b0, 32'd5, 32'hBAD0_BAD6);
    applyStimulus("fail5");
    startRun(-1);

    // Toggling 5/6 never terminates by code: timeout after MAX_CYC cycles.
    curSeq = {};
    for (int i = 0; i < 25; i++) curSeq.push_back((i % 2 == 0) ? 32'd5 : 32'd6);
    modelRun();
    applyStimulus("timeout");
    checkOutput("timeout_const_count", cycleCount, MAX_CYC);
    startRun(-1);

    // Pseudo-random small values, then pass.
    curSeq = {};
    for (int i = 0; i < 11; i++) curSeq.push_back(32'($urandom_range(0, 3)));
    curSeq.push_back(PASSC);
    modelRun();
    applyStimulus("random");

    // A start pulse in the middle of HOLD must not stretch the hold.
    startRun(1);

    // Constant test_out: hang when enabled, timeout otherwise.
    curSeq = {};
    repeat (25) curSeq.push_back(32'd7);
`ifdef CPU_RUN_HANG_DETECT_EN
    pushExp(1'b0, 1'b1, 1'b0, 1'b1, 32'd8, 32'd7);
`else
    pushExp(1'b0, 1'b0, 1'b1, 1'b0, 32'd20, 32'd7);
`endif
    applyStimulus("const7");
    startRun(-1);

    // Abort mid-run with rest; start during RUN is ignored.
    for (int i = 0; i < 7; i++) begin
      testOut = 32'(i + 1);
      start = (i == 2);
      tick();
      start = 1'b0;
      if (i == 2) checkOutput("run_start_ignored", running, 1);
    end
    checkOutput("abort_pre_count", cycleCount, 7);
    checkOutput("abort_pre_done", done, 0);
    rest = 1'b0;
    tick();
    checkReset("abort");
    rest = 1'b1;
    checkHold(-1);

    // Pass code on the very first run cycle.
    curSeq = {PASSC};
    pushExp(1'b1, 1'b0, 1'b0, 1'b0, 32'd1, PASSC);
    applyStimulus("pass1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
